// File: rtl/ibex_l2_regfile_responder.sv
// Second-level register file behind the L1 regfile: 32 x DataWidth storage,
// 2-entry in-order request FIFO, and an IDLE/ACCESS/RESP sequencer with fixed access latency.
module ibex_l2_regfile_responder #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Latency   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [4:0]           req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic [4:0]           rsp_addr_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [4:0]           addr;
        logic [DataWidth-1:0] wdata;
    } entry_t;

    localparam logic [1:0] RELOAD = 2'(Latency - 1);

    state_t               state, next_state;
    logic [1:0]           cnt, next_cnt;
    entry_t               fifo [2];
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           count;
    entry_t               active;
    logic [DataWidth-1:0] storage [32];

    logic fifo_empty, fifo_full, push, pop, commit, capture;

    assign fifo_empty  = (count == 2'd0);
    assign fifo_full   = (count == 2'd2);
    assign req_ready_o = !fifo_full && !rst_i;
    assign push        = req_valid_i && req_ready_o;
    assign rsp_valid_o = (state == RESP);
    assign busy_o      = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Completion of one operation and pop of the next happen on the same edge,
    // so back-to-back operations never pass through IDLE.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        pop        = 1'b0;
        commit     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_cnt   = RELOAD;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 2'd0) begin
                    next_cnt = cnt - 2'd1;
                end else if (active.we) begin
                    commit = 1'b1;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        next_cnt = RELOAD;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_cnt   = RELOAD;
                        next_state = ACCESS;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            fifo[0] <= '0;
            fifo[1] <= '0;
            active <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                active <= fifo[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 32; i++) begin
                storage[i] <= '0;
            end
            rsp_rdata_o <= '0;
            rsp_addr_o  <= '0;
        end else begin
            if (commit && (active.addr != 5'd0)) begin
                storage[active.addr] <= active.wdata;
            end
            if (capture) begin
                rsp_rdata_o <= (active.addr == 5'd0) ? '0 : storage[active.addr];
                rsp_addr_o  <= active.addr;
            end
        end
    end

endmodule

// File: doc/ibex_l2_regfile_responder.md
IBEX_L2_REGFILE_RESPONDER -- requirements
Module: ibex_l2_regfile_responder

Interface
REQ-001 Parameter DataWidth, default 32: width of every stored register and of the data ports.
REQ-002 Parameter Latency, default 2, legal range 1..4: access cycles per request spent in ACCESS.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 req_valid_i  input  1  request from the L1 register file is present.
REQ-006 req_ready_o  output  1  responder accepts a request this cycle.
REQ-007 req_we_i  input  1  1 = write, 0 = read.
REQ-008 req_addr_i  input  5  target register index 0..31.
REQ-009 req_wdata_i  input  DataWidth  write data; ignored for reads.
REQ-010 rsp_valid_o  output  1  read response is present.
REQ-011 rsp_ready_i  input  1  requester consumes the response.
REQ-012 rsp_rdata_o  output  DataWidth  read data.
REQ-013 rsp_addr_o  output  5  register index of the returned data.
REQ-014 busy_o  output  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-015 Storage: 32 x DataWidth registers; index 0 reads as 0; writes to index 0 are discarded.
REQ-016 Request transfer: occurs on a rising edge where req_valid_i && req_ready_o; {we, addr, wdata} are pushed into a 2-entry in-order FIFO.
REQ-017 req_ready_o = !fifo_full && !rst_i; there is no same-cycle bypass while the FIFO is full.
REQ-018 FSM states: IDLE, ACCESS, RESP.
REQ-019 IDLE -> ACCESS on the edge where the FIFO is non-empty: pop the head into the active slot and load the down-counter with Latency-1.
REQ-020 In ACCESS the counter decrements on each edge while non-zero.
REQ-021 ACCESS with counter==0, write: commit storage[addr] <= wdata on that edge; then go to ACCESS (pop the next entry and reload the counter) if the FIFO is non-empty, else go to IDLE; no response is generated.
REQ-022 ACCESS with counter==0, read: capture storage[addr] into rsp_rdata_o and addr into rsp_addr_o, then go to RESP.
REQ-023 In RESP, rsp_valid_o = 1, and rsp_rdata_o/rsp_addr_o hold stable until rsp_valid_o && rsp_ready_i.
REQ-024 On the RESP handshake edge: go to ACCESS (pop and reload) if the FIFO is non-empty, else IDLE.
REQ-025 rsp_valid_o is 0 in IDLE and ACCESS.
REQ-026 Latency: a read accepted at edge N on an idle, empty block asserts rsp_valid_o after edge N+1+Latency; a write commits at edge N+1+Latency.
REQ-027 Ordering: requests complete strictly in acceptance order, so a read following a write to the same index returns the new data.
REQ-028 A FIFO push and pop on the same edge leave the occupancy unchanged.
REQ-029 The FIFO pointers wrap modulo 2.

Reset
REQ-030 While rst_i is high at an edge, the block SHALL clear all storage to 0, empty the FIFO, set the FSM to IDLE, clear the counter, and drive rsp_valid_o=0, rsp_rdata_o=0, rsp_addr_o=0, busy_o=0.
REQ-031 Reset asserted mid-ACCESS or mid-RESP SHALL abort the operation: no commit and no response.

Verification
REQ-032 Reset, then write addr 5 = 0xDEADBEEF at edge 0, then read addr 5 -> rsp_valid_o high with rsp_rdata_o=0xDEADBEEF and rsp_addr_o=5.
REQ-033 Latency=2, idle block, read of addr 7 accepted at edge 10 -> rsp_valid_o first high after edge 13.
REQ-034 Write addr 0 = 0x1234, then read addr 0 -> rsp_rdata_o=0.
REQ-035 Three back-to-back requests with rsp_ready_i=0 -> req_ready_o drops to 0 once 2 entries are queued; rsp_valid_o stays high with stable data; all three complete in order once rsp_ready_i=1.
REQ-036 Write addr 9 = 0xA5A5A5A5 immediately followed by a read of addr 9 -> response 0xA5A5A5A5.
REQ-037 rst_i pulsed during ACCESS of a write to addr 3 -> later read of addr 3 returns 0, and busy_o=0 after the reset edge.
